// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexes one BCD-to-7-segment decoder/driver across DIGITS
// common-anode positions. A double-buffered frame (pending/active) is scanned
// digit by digit. Each digit is preceded by a blanked gap so the old segment
// pattern cannot ghost onto the next digit. Lamp test and leading-zero
// blanking are also handled here.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   enable     scan enable; 0 forces IDLE
//   lzb_en     leading-zero blanking enable
//   wr_en      one-cycle strobe: capture wr_data into the pending frame
//   wr_data    BCD frame, digit i at [4i+3:4i]
//   lt_req     one-cycle strobe: request one lamp-test phase
//   seg_data   driver inbus
//   seg_le     driver latch enable (0 = transparent)
//   seg_lt     driver lamp test (0 = lamp test)
//   seg_bl     driver blanking (0 = blank)
//   digit_sel  one-hot digit enable, active-high
//   frame_done one-cycle pulse at the end of the last digit's dwell
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
   parameter int DIGITS    = 4,
   parameter int DWELL     = 1000,
   parameter int GAP       = 16,
   parameter int LT_CYCLES = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  lzb_en,
   input  logic                  wr_en,
   input  logic [4*DIGITS-1:0]   wr_data,
   input  logic                  lt_req,
   output logic [3:0]            seg_data,
   output logic                  seg_le,
   output logic                  seg_lt,
   output logic                  seg_bl,
   output logic [DIGITS-1:0]     digit_sel,
   output logic                  frame_done
);

   localparam int MAX_DG = (DWELL > GAP) ? DWELL : GAP;
   localparam int MAXC   = (MAX_DG > LT_CYCLES) ? MAX_DG : LT_CYCLES;
   localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int IW     = $clog2(DIGITS);

   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] LT_LAST    = CW'(LT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GAP,
      ST_SHOW,
      ST_LAMP
   } state_t;

   state_t                   state_reg, state_next;
   logic [IW-1:0]            idx_reg, idx_next;
   logic [CW-1:0]            cnt_reg, cnt_next;
   logic [DIGITS-1:0][3:0]   active_reg, active_next;
   logic [DIGITS-1:0][3:0]   pend_reg, pend_next;
   logic                     pend_flag_reg, pend_flag_next;
   logic                     lt_flag_reg, lt_flag_next;

   logic [3:0]               seg_data_reg, seg_data_next;
   logic                     seg_le_reg, seg_le_next;
   logic                     seg_lt_reg, seg_lt_next;
   logic                     seg_bl_reg, seg_bl_next;
   logic [DIGITS-1:0]        digit_sel_reg, digit_sel_next;
   logic                     frame_done_reg, frame_done_next;

   logic                     commit;
   logic                     frame_end;
   logic [DIGITS-1:0]        digit_zero;
   logic                     lzb_hit;
   logic                     show_lit;

   // -----------------------------------------------------------------------
   // Scan sequencing, frame buffering and sticky request flags
   // -----------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      cnt_next       = cnt_reg;
      active_next    = active_reg;
      pend_next      = pend_reg;
      pend_flag_next = pend_flag_reg;
      lt_flag_next   = lt_flag_reg;
      commit         = 1'b0;
      frame_end      = 1'b0;

      if (!enable) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               commit     = 1'b1;
               idx_next   = '0;
               cnt_next   = '0;
               state_next = ST_GAP;
            end
            ST_GAP: begin
               if (cnt_reg == GAP_LAST) begin
                  cnt_next   = '0;
                  state_next = ST_SHOW;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            ST_SHOW: begin
               if (cnt_reg == DWELL_LAST) begin
                  cnt_next = '0;
                  if (idx_reg != IDX_LAST) begin
                     idx_next   = idx_reg + 1'b1;
                     state_next = ST_GAP;
                  end else begin
                     frame_end = 1'b1;
                     commit    = 1'b1;
                     idx_next  = '0;
                     if (lt_flag_reg) begin
                        lt_flag_next = 1'b0;
                        state_next   = ST_LAMP;
                     end else begin
                        state_next = ST_GAP;
                     end
                  end
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            ST_LAMP: begin
               if (cnt_reg == LT_LAST) begin
                  cnt_next   = '0;
                  idx_next   = '0;
                  state_next = ST_GAP;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            default: begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end
         endcase
      end

      // Commit reads the pending buffer as it was before this cycle's write,
      // so a write landing on a commit cycle stays pending for the next one.
      if (commit && pend_flag_reg) begin
         active_next    = pend_reg;
         pend_flag_next = 1'b0;
      end
      if (wr_en) begin
         pend_next      = wr_data;
         pend_flag_next = 1'b1;
      end
      // A request arriving on the clearing cycle is kept for the next frame.
      if (lt_req) begin
         lt_flag_next = 1'b1;
      end
   end

   // -----------------------------------------------------------------------
   // Leading-zero detection on the frame that will be displayed
   // -----------------------------------------------------------------------
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero
      assign digit_zero[gi] = (active_next[gi] == 4'd0);
   end

   // A digit is a leading zero when it and every more-significant digit are
   // zero; digit 0 is never suppressed so an all-zero frame still shows "0".
   always_comb begin
      lzb_hit = lzb_en && (idx_next != '0);
      for (int i = 0; i < DIGITS; i++) begin
         if ((i >= int'(idx_next)) && !digit_zero[i]) begin
            lzb_hit = 1'b0;
         end
      end
      show_lit = (active_next[idx_next] <= 4'd9) && !lzb_hit;
   end

   // -----------------------------------------------------------------------
   // Output decode from the next state, so outputs register alongside it
   // -----------------------------------------------------------------------
   always_comb begin
      seg_data_next   = seg_data_reg;
      seg_le_next     = 1'b1;
      seg_lt_next     = 1'b1;
      seg_bl_next     = 1'b0;
      digit_sel_next  = '0;
      frame_done_next = frame_end;

      case (state_next)
         ST_GAP: begin
            seg_le_next   = 1'b0;
            seg_data_next = active_next[idx_next];
         end
         ST_SHOW: begin
            seg_le_next    = 1'b0;
            seg_bl_next    = show_lit;
            digit_sel_next = DIGITS'(1) << idx_next;
         end
         ST_LAMP: begin
            seg_le_next    = 1'b0;
            seg_lt_next    = 1'b0;
            seg_bl_next    = 1'b1;
            digit_sel_next = '1;
         end
         default: begin
            seg_le_next = 1'b1;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // Registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         idx_reg        <= '0;
         cnt_reg        <= '0;
         active_reg     <= '0;
         pend_reg       <= '0;
         pend_flag_reg  <= 1'b0;
         lt_flag_reg    <= 1'b0;
         seg_data_reg   <= 4'd0;
         seg_le_reg     <= 1'b1;
         seg_lt_reg     <= 1'b1;
         seg_bl_reg     <= 1'b0;
         digit_sel_reg  <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         idx_reg        <= idx_next;
         cnt_reg        <= cnt_next;
         active_reg     <= active_next;
         pend_reg       <= pend_next;
         pend_flag_reg  <= pend_flag_next;
         lt_flag_reg    <= lt_flag_next;
         seg_data_reg   <= seg_data_next;
         seg_le_reg     <= seg_le_next;
         seg_lt_reg     <= seg_lt_next;
         seg_bl_reg     <= seg_bl_next;
         digit_sel_reg  <= digit_sel_next;
         frame_done_reg <= frame_done_next;
      end
   end

   assign seg_data   = seg_data_reg;
   assign seg_le     = seg_le_reg;
   assign seg_lt     = seg_lt_reg;
   assign seg_bl     = seg_bl_reg;
   assign digit_sel  = digit_sel_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
//
// Scoreboard bench. A reference model tracks the display as a position
// within the frame timeline (digit = pos / (GAP+DWELL), gap while the
// remainder is below GAP) and pushes the expected outputs for every clock
// into a queue. A separate monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

   localparam int DIGITS    = 4;
   localparam int DWELL     = 4;
   localparam int GAP       = 2;
   localparam int LT_CYCLES = 8;
   localparam int SLOT      = GAP + DWELL;
   localparam int FRAME     = DIGITS * SLOT;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                enable = 1'b0;
   logic                lzb_en = 1'b0;
   logic                wr_en = 1'b0;
   logic [4*DIGITS-1:0] wr_data = '0;
   logic                lt_req = 1'b0;
   logic [3:0]          seg_data;
   logic                seg_le;
   logic                seg_lt;
   logic                seg_bl;
   logic [DIGITS-1:0]   digit_sel;
   logic                frame_done;

   seven_seg_scan_ctrl #(
      .DIGITS    (DIGITS),
      .DWELL     (DWELL),
      .GAP       (GAP),
      .LT_CYCLES (LT_CYCLES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .lzb_en     (lzb_en),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .lt_req     (lt_req),
      .seg_data   (seg_data),
      .seg_le     (seg_le),
      .seg_lt     (seg_lt),
      .seg_bl     (seg_bl),
      .digit_sel  (digit_sel),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]        data;
      logic              le;
      logic              lt;
      logic              bl;
      logic [DIGITS-1:0] sel;
      logic              fd;
   } out_t;

   out_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   // Reference model state
   bit   m_run    = 1'b0;
   bit   m_lamp   = 1'b0;
   int   m_pos    = 0;
   int   m_act[DIGITS];
   int   m_pend[DIGITS];
   bit   m_pflag  = 1'b0;
   bit   m_ltflag = 1'b0;
   int   m_data   = 0;

   task automatic model_step();
      out_t e;
      bit   fd;
      bit   commit;
      int   d;
      int   w;
      bit   lead;
      fd     = 1'b0;
      commit = 1'b0;
      if (rst) begin
         m_run = 0; m_lamp = 0; m_pos = 0; m_pflag = 0; m_ltflag = 0; m_data = 0;
         for (int i = 0; i < DIGITS; i++) begin
            m_act[i]  = 0;
            m_pend[i] = 0;
         end
         e = '{data: 4'd0, le: 1'b1, lt: 1'b1, bl: 1'b0, sel: '0, fd: 1'b0};
      end else begin
         if (!enable) begin
            m_run = 0;
         end else if (!m_run) begin
            m_run  = 1;
            m_lamp = 0;
            m_pos  = 0;
            commit = 1;
         end else begin
            m_pos++;
            if (m_lamp && m_pos == LT_CYCLES) begin
               m_lamp = 0;
               m_pos  = 0;
            end else if (!m_lamp && m_pos == FRAME) begin
               m_pos  = 0;
               fd     = 1;
               commit = 1;
               if (m_ltflag) begin
                  m_ltflag = 0;
                  m_lamp   = 1;
               end
            end
         end
         if (commit && m_pflag) begin
            for (int i = 0; i < DIGITS; i++) m_act[i] = m_pend[i];
            m_pflag = 0;
         end
         if (wr_en) begin
            for (int i = 0; i < DIGITS; i++) m_pend[i] = int'(wr_data[4*i +: 4]);
            m_pflag = 1;
         end
         if (lt_req) m_ltflag = 1;

         e = '{data: 4'(m_data), le: 1'b1, lt: 1'b1, bl: 1'b0, sel: '0, fd: fd};
         if (m_run && m_lamp) begin
            e.le  = 1'b0;
            e.lt  = 1'b0;
            e.bl  = 1'b1;
            e.sel = '1;
         end else if (m_run) begin
            d    = m_pos / SLOT;
            w    = m_pos % SLOT;
            e.le = 1'b0;
            if (w < GAP) begin
               m_data = m_act[d];
               e.data = 4'(m_data);
            end else begin
               e.sel = DIGITS'(1 << d);
               lead  = (lzb_en && d > 0);
               for (int k = d; k < DIGITS; k++) if (m_act[k] != 0) lead = 0;
               e.bl  = !(m_act[d] > 9 || lead);
            end
         end
      end
      exp_q.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Monitor: compares outputs against the queued expectation
   initial begin
      out_t e;
      out_t got;
      forever begin
         @(negedge clk);
         cycle++;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{data: seg_data, le: seg_le, lt: seg_lt, bl: seg_bl,
                    sel: digit_sel, fd: frame_done};
            checks++;
            if (got !== e) begin
               errors++;
               if (errors <= 25)
                  $display("FAIL outputs cycle %0d: got data=%h le=%b lt=%b bl=%b sel=%b fd=%b, exp data=%h le=%b lt=%b bl=%b sel=%b fd=%b",
                           cycle, got.data, got.le, got.lt, got.bl, got.sel, got.fd,
                           e.data, e.le, e.lt, e.bl, e.sel, e.fd);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_write(input logic [4*DIGITS-1:0] v);
      $display("txn cycle %0d: write frame 0x%h", cycle, v);
      wr_data = v;
      wr_en   = 1'b1;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic do_lt();
      $display("txn cycle %0d: lamp-test request", cycle);
      lt_req = 1'b1;
      @(negedge clk);
      lt_req = 1'b0;
   endtask

   function automatic logic [4*DIGITS-1:0] rand_frame();
      logic [4*DIGITS-1:0] v;
      int r;
      v = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r = $urandom_range(0, 7);
         if (r >= 4 && r <= 6) v[4*i +: 4] = 4'($urandom_range(1, 9));
         else if (r == 7)      v[4*i +: 4] = 4'($urandom_range(10, 15));
      end
      return v;
   endfunction

   initial begin
      int budget;
      // Reset and idle
      $display("txn cycle %0d: reset", cycle);
      tick(3);
      rst = 1'b0;
      tick(3);

      // 1: zero frame, plain scan
      $display("txn cycle %0d: enable, zero frame", cycle);
      enable = 1'b1;
      tick(2 * FRAME + 2);

      // 2: mid-frame write must wait for frame end
      tick(7);
      do_write(16'h1234);
      tick(2 * FRAME);

      // 3: leading-zero blanking
      lzb_en = 1'b1;
      do_write(16'h0050);
      tick(2 * FRAME);
      do_write(16'h0000);
      tick(2 * FRAME);

      // 4: lamp test requested during a scan
      do_write(16'h5678);
      tick(SLOT + 3);
      do_lt();
      tick(3 * FRAME + LT_CYCLES);

      // 5: invalid BCD digit
      do_write(16'hA009);
      tick(2 * FRAME);

      // Write landing exactly on the frame-end commit cycle
      budget = 0;
      while (!(m_run && !m_lamp && m_pos == FRAME - 1) && budget < 100) begin
         tick(1);
         budget++;
      end
      checks++;
      if (budget >= 100) begin
         errors++;
         $display("FAIL frame_end_wait: got budget=%0d required <100", budget);
      end
      do_write(16'h4321);
      tick(2 * FRAME + 4);

      // 6: disable mid-SHOW, re-enable, then reset mid-SHOW
      tick(GAP + 1);
      $display("txn cycle %0d: disable", cycle);
      enable = 1'b0;
      tick(4);
      $display("txn cycle %0d: re-enable", cycle);
      enable = 1'b1;
      tick(FRAME + GAP + 2);
      $display("txn cycle %0d: reset mid-scan", cycle);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(FRAME + 4);

      // Randomized traffic
      for (int c = 0; c < 800; c++) begin
         wr_en  = ($urandom_range(0, 15) == 0);
         if (wr_en) begin
            wr_data = rand_frame();
            $display("txn cycle %0d: write frame 0x%h", cycle, wr_data);
         end
         lt_req = ($urandom_range(0, 63) == 0);
         if (lt_req) $display("txn cycle %0d: lamp-test request", cycle);
         if ($urandom_range(0, 31) == 0) lzb_en = ~lzb_en;
         if (!enable) enable = ($urandom_range(0, 3) == 0);
         else         enable = ($urandom_range(0, 149) != 0);
         rst = ($urandom_range(0, 499) == 0);
         if (rst) $display("txn cycle %0d: reset", cycle);
         @(negedge clk);
      end
      wr_en  = 1'b0;
      lt_req = 1'b0;
      rst    = 1'b0;
      enable = 1'b1;
      tick(FRAME + 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexing scanner that shares one 7-segment decoder/driver (4-bit inbus, active-low le/lt/bl) between DIGITS common-anode digit positions. It holds a double-buffered frame of BCD digits and steps through them with a dwell period and an anti-ghosting blank gap. It sequences the driver's lamp-test and blanking controls and provides leading-zero blanking. It sits between the host/register logic and the decoder plus digit-select transistors.

Parameters:
DIGITS, 4, number of multiplexed digit positions (>=2); digit 0 is least significant.
DWELL, 1000, clock cycles each digit is displayed (>=1).
GAP, 16, clock cycles all digits are off between digits (>=1).
LT_CYCLES, 50000, clock cycles of the lamp-test phase (>=1).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
enable  in  1  scan enable; 0 forces IDLE.
lzb_en  in  1  leading-zero blanking enable.
wr_en  in  1  one-cycle strobe: capture wr_data into the pending frame.
wr_data  in  4*DIGITS  BCD frame; digit i is at [4i+3:4i].
lt_req  in  1  one-cycle strobe: request one lamp-test phase.
seg_data  out  4  to driver inbus.
seg_le  out  1  to driver le (0 = transparent).
seg_lt  out  1  to driver lt (0 = lamp test).
seg_bl  out  1  to driver bl (0 = blank).
digit_sel  out  DIGITS  one-hot digit enable, active-high.
frame_done  out  1  one-cycle pulse at the end of the last digit's dwell.

Behaviour:
- All outputs are registered. Reset values: seg_data=0, seg_le=1, seg_lt=1, seg_bl=0, digit_sel=0, frame_done=0. Internal reset values: state=IDLE, idx=0, active frame=0, pending frame=0, pend_flag=0, lt_flag=0, counter=0.
- wr_en loads the pending frame and sets pend_flag. A later wr_en before commit overwrites the pending frame (last write wins). The pending frame is committed to the active frame only at IDLE->GAP or at frame end, so a frame never tears mid-scan.
- lt_req sets lt_flag (sticky) in any state, including IDLE.
- IDLE: digit_sel=0, seg_bl=0, seg_le=1, seg_lt=1. When enable=1, commit the pending frame if pend_flag is set, set idx=0, and go to GAP.
- GAP: digit_sel=0, seg_bl=0, seg_le=0, seg_lt=1. seg_data is loaded with active[idx] on entry. After exactly GAP cycles, go to SHOW.
- SHOW: digit_sel=1<<idx, seg_le=0, seg_lt=1.
  - seg_bl=0 if active[idx]>9.
  - seg_bl=0 if lzb_en=1, idx>0, and active[idx] and all more-significant digits are 0.
  - Otherwise seg_bl=1.
  - After exactly DWELL cycles:
    - If idx<DIGITS-1: idx+1, go to GAP.
    - Else: pulse frame_done for 1 cycle, commit the pending frame if pend_flag is set, set idx=0. If lt_flag is set, clear it and go to LAMP; else go to GAP.
- LAMP: digit_sel=all ones, seg_lt=0, seg_bl=1, seg_le=0. After LT_CYCLES, go to GAP with idx=0.
- enable=0 in any state: the next state is IDLE, the counter clears, and pend_flag/lt_flag are retained.
- Simultaneous wr_en and commit in the same cycle: the commit uses the frame stored before the write; the new data stays pending with pend_flag=1.
- Frame period = DIGITS*(GAP+DWELL) cycles, plus LT_CYCLES when a lamp test runs.
- rst asserted mid-scan forces the reset values on the next edge, regardless of enable.

Test Plan:
(Bench uses DIGITS=4, DWELL=4, GAP=2, LT_CYCLES=8.)
1. Reset then enable=1 with a zero frame, lzb_en=0 -> seg_bl=0/digit_sel=0 for 2 cycles, then digit_sel=0001 with seg_data=0 and seg_bl=1 for 4 cycles; the pattern repeats for 0010, 0100, 1000; frame_done pulses every 24 cycles.
2. Write 0x1234 mid-frame -> display is unchanged until frame_done; the next frame shows seg_data 4,3,2,1 on digit_sel 0001..1000.
3. lzb_en=1, frame 0x0050 -> digit3 and digit2 have seg_bl=0; digit1 (5) and digit0 (0) have seg_bl=1.
4. lt_req during digit1 -> at frame end: digit_sel=1111, seg_lt=0, seg_bl=1 for 8 cycles, then GAP and digit 0; a second frame runs with no lamp test.
5. Frame 0xA009 -> digit3 has seg_bl=0 (invalid BCD); digit0 shows 9 with seg_bl=1.
6. enable=0 during SHOW -> IDLE next cycle (digit_sel=0, seg_le=1, seg_bl=0); re-enable -> GAP with idx=0. rst mid-SHOW -> all reset values.
